axi_b_response_arbiter: RTL and testbench
=========================================

Name: axi_b_response_arbiter

Overview:
- Write-response (B channel) return path for one target (master-side) port of the AXI node.
- Arbitrates B responses from N_INIT_PORT slave-side ports, plus one locally generated DECERR error response, onto a single B output.
- Keeps the per-target outstanding-write counter; its status outputs feed the AW address decoder's outstanding-transaction and full-counter inputs.

Parameters:
- N_INIT_PORT, 8, number of slave-side (initiator) ports feeding B responses.
- ID_WIDTH, 6, BID width.
- USER_WIDTH, 6, BUSER width.
- MAX_OUTSTANDING, 8, outstanding-write capacity; counter width is $clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- bvalid_i  in  N_INIT_PORT  per-slave B valid, already filtered for this target.
- bid_i  in  N_INIT_PORT*ID_WIDTH  per-slave BID.
- bresp_i  in  N_INIT_PORT*2  per-slave BRESP.
- buser_i  in  N_INIT_PORT*USER_WIDTH  per-slave BUSER.
- bready_o  out  N_INIT_PORT  per-slave B ready.
- bvalid_o  out  1  merged B valid.
- bid_o  out  ID_WIDTH  merged BID.
- bresp_o  out  2  merged BRESP.
- buser_o  out  USER_WIDTH  merged BUSER.
- bready_i  in  1  target B ready.
- error_req_i  in  1  decoder requests a DECERR response.
- error_id_i  in  ID_WIDTH  AWID captured for the errored transaction.
- error_gnt_o  out  1  DECERR response accepted.
- incr_req_i  in  1  decoder issued a new write.
- outstanding_trans_o  out  1  counter is non-zero.
- full_counter_o  out  1  counter equals MAX_OUTSTANDING.

Behaviour:
- Requesters are indices 0..N_INIT_PORT-1 (slaves) and index N_INIT_PORT (error source, req = error_req_i).
- Arbitration is round-robin over N_INIT_PORT+1 requesters. rr_q holds the last granted index; the search starts at rr_q+1, wrapping modulo N_INIT_PORT+1.
- Lock rule: if bvalid_o=1 and bready_i=0, lock_q<=1 and sel_q<=current grant. While locked, the grant is forced to sel_q and ignores other requests, so payload stays stable per AXI.
- Handshake (bvalid_o & bready_i): rr_q<=granted index, lock_q<=0.
- bvalid_o = any request while unlocked, or 1 while locked. Output payload is a combinational mux of the granted source, so latency is 0 cycles.
- Error source payload: bid=error_id_i, bresp=RESP_DECERR (2'b11), buser='0.
- bready_o[i] = bready_i & grant[i]; error_gnt_o = bready_i & grant[N_INIT_PORT].
- Counter: +1 on incr_req_i; -1 on any B handshake, including DECERR. Simultaneous +1/-1 leaves it unchanged.
- Counter boundaries: saturates at MAX_OUTSTANDING (incr while full is ignored) and at 0 (decrement at 0 is ignored).
- outstanding_trans_o = (cnt!=0); full_counter_o = (cnt==MAX_OUTSTANDING). Both are registered-state derived, not from same-cycle inputs.
- Reset values: rr_q=N_INIT_PORT (first search begins at 0), lock_q=0, sel_q=0, cnt=0. All outputs are 0 in reset.
- Reset asserted mid-handshake drops bvalid_o immediately; no response is replayed.

Optional Feature:
- Macro: AXI_B_OUT_REG_EN.
- Defined: one-entry output register after the mux.
  - Mux handshake condition becomes (!full_q | bready_i); the lock rule applies to the mux against that ready.
  - Register loads on mux handshake, clears on output handshake when not reloaded.
  - Latency is 1 cycle at full throughput. Counter decrements on the output handshake. full_q resets to 0.
- Undefined: purely combinational path as described above.

Decomposition:
- Package axi_node_pkg: RESP_OKAY=2'b00, RESP_DECERR=2'b11, and an ID/resp/user B-payload struct typedef.
- Sub-module axi_b_rr_arbiter: N+1-way round-robin with grant lock. Outputs are a one-hot grant plus a binary index; it is reusable by the R path.

Test Plan:
- Reset, then bvalid_i=8'b0000_0101 with bready_i=1 -> grants port 0, then port 2 on consecutive cycles; bid_o follows each.
- Port 3 valid, bready_i=0 for 4 cycles while port 1 raises valid -> bvalid_o and bid_o stay on port 3 until the handshake, then port 1.
- error_req_i=1, error_id_i=6'h2A, bready_i=1 -> bvalid_o=1, bid_o=6'h2A, bresp_o=2'b11, error_gnt_o=1 for one cycle.
- 8 incr_req_i pulses with no B -> full_counter_o=1; a 9th incr leaves the count at 8; one B handshake -> full_counter_o=0.
- incr_req_i and a B handshake in the same cycle with cnt=3 -> cnt stays 3; drain to 0 -> outstanding_trans_o=0.
- AXI_B_OUT_REG_EN defined, continuous valid on ports 0 and 1 with bready_i=1 -> first output 1 cycle after the input, then one response per cycle.

Source files
------------

// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: response codes and the canonical B-channel payload layout.
package axi_node_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int AXI_ID_WIDTH   = 6;
  localparam int AXI_USER_WIDTH = 6;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [1:0]                resp;
    logic [AXI_USER_WIDTH-1:0] user;
  } b_payload_t;

endpackage

// File: rtl/axi_b_rr_arbiter.sv
// N_REQ-way round-robin arbiter with grant lock: once valid is shown without ready,
// the grant holds until the handshake. Shared by the B and R return paths.
module axi_b_rr_arbiter #(
  parameter  int N_REQ = 9,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             ready,
  output logic             valid,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] sel_q;
  logic             lock_q;
  logic [IDX_W-1:0] pick_idx;
  logic             found;
  int               cand;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(rr_q) + k) % N_REQ;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found    = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign grant_idx = lock_q ? sel_q : pick_idx;
  assign valid     = lock_q | found;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
    assign grant[gi] = valid && (grant_idx == IDX_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q   <= IDX_W'(N_REQ - 1);
      sel_q  <= '0;
      lock_q <= 1'b0;
    end else if (valid && ready) begin
      rr_q   <= grant_idx;
      lock_q <= 1'b0;
    end else if (valid) begin
      lock_q <= 1'b1;
      sel_q  <= grant_idx;
    end
  end

endmodule

// File: rtl/axi_b_response_arbiter.sv
// B-channel return path for one target port: merges slave B responses plus a local DECERR
// source, and tracks outstanding writes. Define AXI_B_OUT_REG_EN for a registered output stage.
module axi_b_response_arbiter
  import axi_node_pkg::*;
#(
  parameter int N_INIT_PORT     = 8,
  parameter int ID_WIDTH        = 6,
  parameter int USER_WIDTH      = 6,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_INIT_PORT-1:0]            bvalid_i,
  input  logic [N_INIT_PORT*ID_WIDTH-1:0]   bid_i,
  input  logic [N_INIT_PORT*2-1:0]          bresp_i,
  input  logic [N_INIT_PORT*USER_WIDTH-1:0] buser_i,
  output logic [N_INIT_PORT-1:0]            bready_o,
  output logic                              bvalid_o,
  output logic [ID_WIDTH-1:0]               bid_o,
  output logic [1:0]                        bresp_o,
  output logic [USER_WIDTH-1:0]             buser_o,
  input  logic                              bready_i,
  input  logic                              error_req_i,
  input  logic [ID_WIDTH-1:0]               error_id_i,
  output logic                              error_gnt_o,
  input  logic                              incr_req_i,
  output logic                              outstanding_trans_o,
  output logic                              full_counter_o
);

  localparam int N_REQ = N_INIT_PORT + 1;
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Same layout as axi_node_pkg::b_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [1:0]            resp;
    logic [USER_WIDTH-1:0] user;
  } b_beat_t;

  b_beat_t          src [N_REQ];
  b_beat_t          mux_b;
  b_beat_t          b_out;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             arb_valid;
  logic             mux_ready;
  logic             b_hs;
  logic [CNT_W-1:0] cnt_q;

  for (genvar gi = 0; gi < N_INIT_PORT; gi++) begin : g_src
    assign src[gi] = '{id:   bid_i[gi*ID_WIDTH +: ID_WIDTH],
                       resp: bresp_i[gi*2 +: 2],
                       user: buser_i[gi*USER_WIDTH +: USER_WIDTH]};
  end
  assign src[N_INIT_PORT] = '{id: error_id_i, resp: RESP_DECERR, user: '0};

  assign req = {error_req_i, bvalid_i};

  axi_b_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ready     (mux_ready),
    .valid     (arb_valid),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    mux_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) mux_b = src[i];
    end
  end

`ifdef AXI_B_OUT_REG_EN
  logic    full_q;
  b_beat_t out_q;

  assign mux_ready = !full_q || bready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      out_q  <= '0;
    end else if (arb_valid && mux_ready) begin
      full_q <= 1'b1;
      out_q  <= mux_b;
    end else if (bready_i) begin
      full_q <= 1'b0;
    end
  end

  assign bvalid_o = full_q;
  assign b_out    = out_q;
  assign b_hs     = full_q && bready_i;
`else
  assign mux_ready = bready_i;
  // Outputs are gated by rst so an in-flight response vanishes the moment reset asserts.
  assign bvalid_o  = arb_valid && !rst;
  assign b_out     = rst ? '0 : mux_b;
  assign b_hs      = bvalid_o && bready_i;
`endif

  assign bid_o       = b_out.id;
  assign bresp_o     = b_out.resp;
  assign buser_o     = b_out.user;
  assign bready_o    = grant[N_INIT_PORT-1:0] & {N_INIT_PORT{mux_ready && !rst}};
  assign error_gnt_o = grant[N_INIT_PORT] && mux_ready && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (incr_req_i && !b_hs) begin
      if (cnt_q != CNT_W'(MAX_OUTSTANDING)) cnt_q <= cnt_q + 1'b1;
    end else if (b_hs && !incr_req_i) begin
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign outstanding_trans_o = (cnt_q != '0);
  assign full_counter_o      = (cnt_q == CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_axi_b_response_arbiter.sv
// Directed bench for axi_b_response_arbiter: vector table for the combinational build,
// latency sequence when AXI_B_OUT_REG_EN is defined.
module tb_axi_b_response_arbiter;

  localparam int N  = 8;
  localparam int IW = 6;
  localparam int UW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    bvalid_i;
  logic [N*IW-1:0] bid_i;
  logic [N*2-1:0]  bresp_i;
  logic [N*UW-1:0] buser_i;
  logic [N-1:0]    bready_o;
  logic            bvalid_o;
  logic [IW-1:0]   bid_o;
  logic [1:0]      bresp_o;
  logic [UW-1:0]   buser_o;
  logic            bready_i;
  logic            error_req_i;
  logic [IW-1:0]   error_id_i;
  logic            error_gnt_o;
  logic            incr_req_i;
  logic            outstanding_trans_o;
  logic            full_counter_o;

  int checks = 0;
  int errors = 0;

  axi_b_response_arbiter #(
    .N_INIT_PORT     (N),
    .ID_WIDTH        (IW),
    .USER_WIDTH      (UW),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bvalid_i            (bvalid_i),
    .bid_i               (bid_i),
    .bresp_i             (bresp_i),
    .buser_i             (buser_i),
    .bready_o            (bready_o),
    .bvalid_o            (bvalid_o),
    .bid_o               (bid_o),
    .bresp_o             (bresp_o),
    .buser_o             (buser_o),
    .bready_i            (bready_i),
    .error_req_i         (error_req_i),
    .error_id_i          (error_id_i),
    .error_gnt_o         (error_gnt_o),
    .incr_req_i          (incr_req_i),
    .outstanding_trans_o (outstanding_trans_o),
    .full_counter_o      (full_counter_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bvalid;
    logic       bready;
    logic       err_req;
    logic [5:0] err_id;
    logic       incr;
    logic       e_valid;
    logic [5:0] e_bid;
    logic [1:0] e_bresp;
    logic [5:0] e_buser;
    logic [7:0] e_bready;
    logic       e_egnt;
    logic       e_outst;
    logic       e_full;
  } vec_t;

  vec_t vecs [30];

  function automatic logic [25:0] obs();
    return {bvalid_o, bid_o, bresp_o, buser_o, bready_o, error_gnt_o,
            outstanding_trans_o, full_counter_o};
  endfunction

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %07h expected %07h", name, act, exp);
    end else begin
      $display("ok   %s: %07h", name, act);
    end
  endtask

  initial begin
    // Port k: BID 0x10+k, BRESP k%4, BUSER k+1.
    for (int k = 0; k < N; k++) begin
      bid_i[k*IW +: IW]   = 6'(16 + k);
      bresp_i[k*2 +: 2]   = 2'(k % 4);
      buser_i[k*UW +: UW] = 6'(k + 1);
    end
    //                bvalid  rdy er id     inc  v  bid    rsp   usr   rdy_o  eg os fu
    vecs[0]  = '{8'h00, 1, 0, 6'h00, 0,  0, 6'h00, 2'd0, 6'd0, 8'h00, 0, 0, 0};
    vecs[1]  = '{8'h05, 1, 0, 6'h00, 0,  1, 6'h10, 2'd0, 6'd1, 8'h01, 0, 0, 0};
    vecs[2]  = '{8'h05, 1, 0, 6'h00, 0,  1, 6'h12, 2'd2, 6'd3, 8'h04, 0, 0, 0};
    for (int i = 3; i <= 10; i++)
      vecs[i] = '{8'h00, 1, 0, 6'h00, 1,  0, 6'h00, 2'd0, 6'd0, 8'h00, 0, (i > 3), 0};
    vecs[11] = '{8'h00, 1, 0, 6'h00, 1,  0, 6'h00, 2'd0, 6'd0, 8'h00, 0, 1, 1};
    vecs[12] = '{8'h08, 1, 0, 6'h00, 0,  1, 6'h13, 2'd3, 6'd4, 8'h08, 0, 1, 1};
    vecs[13] = '{8'h00, 1, 0, 6'h00, 0,  0, 6'h00, 2'd0, 6'd0, 8'h00, 0, 1, 0};
    vecs[14] = '{8'h08, 0, 0, 6'h00, 0,  1, 6'h13, 2'd3, 6'd4, 8'h00, 0, 1, 0};
    for (int i = 15; i <= 17; i++)
      vecs[i] = '{8'h0A, 0, 0, 6'h00, 0,  1, 6'h13, 2'd3, 6'd4, 8'h00, 0, 1, 0};
    vecs[18] = '{8'h0A, 1, 0, 6'h00, 0,  1, 6'h13, 2'd3, 6'd4, 8'h08, 0, 1, 0};
    vecs[19] = '{8'h02, 1, 0, 6'h00, 0,  1, 6'h11, 2'd1, 6'd2, 8'h02, 0, 1, 0};
    vecs[20] = '{8'h00, 1, 1, 6'h2A, 0,  1, 6'h2A, 2'd3, 6'd0, 8'h00, 1, 1, 0};
    vecs[21] = '{8'h00, 1, 0, 6'h2A, 0,  0, 6'h00, 2'd0, 6'd0, 8'h00, 0, 1, 0};
    vecs[22] = '{8'h01, 1, 0, 6'h2A, 0,  1, 6'h10, 2'd0, 6'd1, 8'h01, 0, 1, 0};
    vecs[23] = '{8'h01, 1, 0, 6'h2A, 1,  1, 6'h10, 2'd0, 6'd1, 8'h01, 0, 1, 0};
    for (int i = 24; i <= 26; i++)
      vecs[i] = '{8'h20, 1, 0, 6'h2A, 0,  1, 6'h15, 2'd1, 6'd6, 8'h20, 0, 1, 0};
    vecs[27] = '{8'h00, 1, 0, 6'h2A, 0,  0, 6'h00, 2'd0, 6'd0, 8'h00, 0, 0, 0};
    vecs[28] = '{8'h01, 1, 1, 6'h2A, 0,  1, 6'h2A, 2'd3, 6'd0, 8'h00, 1, 0, 0};
    vecs[29] = '{8'h01, 1, 1, 6'h2A, 0,  1, 6'h10, 2'd0, 6'd1, 8'h01, 0, 0, 0};

    // Reset with a request already pending: every output must still read 0.
    rst         = 1'b1;
    bvalid_i    = 8'h04;
    bready_i    = 1'b1;
    error_req_i = 1'b1;
    error_id_i  = 6'h00;
    incr_req_i  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", obs(), 26'h0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bvalid_i    = 8'h00;
    error_req_i = 1'b0;

`ifndef AXI_B_OUT_REG_EN
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      bvalid_i    = vecs[i].bvalid;
      bready_i    = vecs[i].bready;
      error_req_i = vecs[i].err_req;
      error_id_i  = vecs[i].err_id;
      incr_req_i  = vecs[i].incr;
      @(negedge clk);
      check($sformatf("vec%0d", i), obs(),
            {vecs[i].e_valid, vecs[i].e_bid, vecs[i].e_bresp, vecs[i].e_buser,
             vecs[i].e_bready, vecs[i].e_egnt, vecs[i].e_outst, vecs[i].e_full});
    end

    // Stall on port 2, then reset mid-transfer: bvalid_o drops at once and port 2 is not replayed.
    @(posedge clk);
    #1;
    bvalid_i    = 8'h04;
    bready_i    = 1'b0;
    error_req_i = 1'b0;
    incr_req_i  = 1'b1;
    @(negedge clk);
    check("stall_port2", obs(), {1'b1, 6'h12, 2'd2, 6'd3, 8'h00, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    incr_req_i = 1'b0;
    @(negedge clk);
    check("stall_hold", obs(), {1'b1, 6'h12, 2'd2, 6'd3, 8'h00, 1'b0, 1'b1, 1'b0});
    rst = 1'b1;
    #1;
    check("reset_mid_hs", obs(), 26'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bvalid_i = 8'h05;
    bready_i = 1'b1;
    @(negedge clk);
    check("after_reset", obs(), {1'b1, 6'h10, 2'd0, 6'd1, 8'h01, 1'b0, 1'b0, 1'b0});
`else
    // Registered output: first beat appears one cycle after the request, then one per cycle.
    @(posedge clk);
    #1;
    bvalid_i = 8'h03;
    bready_i = 1'b1;
    @(negedge clk);
    check("oreg_cycle0", obs(), {1'b0, 6'h00, 2'd0, 6'd0, 8'h01, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("oreg_cycle1", obs(), {1'b1, 6'h10, 2'd0, 6'd1, 8'h02, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("oreg_cycle2", obs(), {1'b1, 6'h11, 2'd1, 6'd2, 8'h01, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("oreg_cycle3", obs(), {1'b1, 6'h10, 2'd0, 6'd1, 8'h02, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    bvalid_i = 8'h00;
    bready_i = 1'b0;
    @(negedge clk);
    check("oreg_hold", obs(), {1'b1, 6'h11, 2'd1, 6'd2, 8'h00, 1'b0, 1'b0, 1'b0});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
